// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Multi-cycle instruction sequencer for a small load/store core.
//               Accepts one instruction from fetch, decodes its fields, steers
//               it through EXEC, an optional memory or divider wait, and a
//               write-back cycle, then returns to FETCH.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   instr_i/_valid_i      instruction from fetch; instr_ready_o = accept now
//   eq_i, gt_i            datapath compare results (ra==rb, ra>rb signed)
//   mem_ready_i           data memory completes the current request
//   div_done_i            divider result valid
//   ra_o rb_o rd_o        register selects (rd_o = rb for LW/LI)
//   alu_op_o, imm_o       ALU opcode, sign-extended 13-bit offset
//   reg_we_o mem_req_o mem_we_o div_start_o pc_en_o pc_sel_o  strobes
//   state_o               FSM state, instr_count_o retired instructions
// Instruction: offset[31:19] ra[18:14] rb[13:9] rd[8:4] opcode[3:0]
// Opcodes: 0 ADD 1 SUB 2 MUL 3 DIV 4 AND 5 OR 6 XOR 7 LW 8 SW 9 LI
//          10 BEQ 11 BGT 12 BGE 13 JMP 14/15 illegal
// Build option: CTRL_ILLEGAL_TRAP_EN - illegal opcodes enter HALT until
//               reset; when undefined they retire as NOPs.
// ============================================================================
module control_unit #(
   parameter int DATAWIDTH = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [31:0]          instr_i,
   input  logic                 instr_valid_i,
   output logic                 instr_ready_o,
   input  logic                 eq_i,
   input  logic                 gt_i,
   input  logic                 mem_ready_i,
   input  logic                 div_done_i,
   output logic [4:0]           ra_o,
   output logic [4:0]           rb_o,
   output logic [4:0]           rd_o,
   output logic [3:0]           alu_op_o,
   output logic [DATAWIDTH-1:0] imm_o,
   output logic                 reg_we_o,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic                 div_start_o,
   output logic                 pc_en_o,
   output logic                 pc_sel_o,
   output logic [2:0]           state_o,
   output logic [31:0]          instr_count_o
);

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXEC    = 3'd2,
      S_MEM     = 3'd3,
      S_DIVWAIT = 3'd4,
      S_WB      = 3'd5,
      S_HALT    = 3'd6
   } state_t;

   localparam logic [3:0] C_OP_XOR = 4'd6;
   localparam logic [3:0] C_OP_DIV = 4'd3;
   localparam logic [3:0] C_OP_LW  = 4'd7;
   localparam logic [3:0] C_OP_SW  = 4'd8;
   localparam logic [3:0] C_OP_LI  = 4'd9;
   localparam logic [3:0] C_OP_BEQ = 4'd10;
   localparam logic [3:0] C_OP_BGT = 4'd11;
   localparam logic [3:0] C_OP_BGE = 4'd12;
   localparam logic [3:0] C_OP_JMP = 4'd13;

   state_t      state_q;
   logic [31:0] instr_q;
   logic [31:0] count_q;
   logic        instr_ready_q;
   logic        reg_we_q;
   logic        mem_req_q;
   logic        mem_we_q;
   logic        div_start_q;
   logic        pc_en_q;
   logic        pc_sel_q;

   // Decode of the latched instruction
   logic [3:0] w_op;
   logic       w_is_alu;
   logic       w_is_mem;
   logic       w_writes;
   logic       w_taken;
   logic       w_trap;

   assign w_op     = instr_q[3:0];
   assign w_is_alu = (w_op <= C_OP_XOR);
   assign w_is_mem = (w_op == C_OP_LW) || (w_op == C_OP_SW);
   assign w_writes = w_is_alu || (w_op == C_OP_LW) || (w_op == C_OP_LI);

   always_comb begin
      w_taken = 1'b0;
      case (w_op)
         C_OP_BEQ: w_taken = eq_i;
         C_OP_BGT: w_taken = gt_i;
         C_OP_BGE: w_taken = eq_i | gt_i;
         C_OP_JMP: w_taken = 1'b1;
         default:  w_taken = 1'b0;
      endcase
   end

`ifdef CTRL_ILLEGAL_TRAP_EN
   assign w_trap = (w_op[3:1] == 3'b111);
`else
   assign w_trap = 1'b0;
`endif

   // Strobes are registered: each one is computed on the edge that enters
   // the state it belongs to, so it lines up exactly with state_o.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= S_FETCH;
         instr_q       <= 32'd0;
         count_q       <= 32'd0;
         instr_ready_q <= 1'b1;
         reg_we_q      <= 1'b0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         div_start_q   <= 1'b0;
         pc_en_q       <= 1'b0;
         pc_sel_q      <= 1'b0;
      end else begin
         instr_ready_q <= 1'b0;
         reg_we_q      <= 1'b0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         div_start_q   <= 1'b0;
         pc_en_q       <= 1'b0;
         pc_sel_q      <= 1'b0;
         case (state_q)
            S_FETCH: begin
               if (instr_valid_i) begin
                  instr_q <= instr_i;
                  state_q <= S_DECODE;
               end else begin
                  instr_ready_q <= 1'b1;
               end
            end
            S_DECODE: begin
               state_q     <= S_EXEC;
               div_start_q <= (w_op == C_OP_DIV);
            end
            S_EXEC: begin
               if (w_is_mem) begin
                  state_q   <= S_MEM;
                  mem_req_q <= 1'b1;
                  mem_we_q  <= (w_op == C_OP_SW);
               end else if (w_op == C_OP_DIV) begin
                  state_q <= S_DIVWAIT;
               end else if (w_trap) begin
                  state_q <= S_HALT;
               end else begin
                  // Branch outcome is decided here from eq_i/gt_i
                  state_q  <= S_WB;
                  pc_en_q  <= 1'b1;
                  pc_sel_q <= w_taken;
                  reg_we_q <= w_writes;
               end
            end
            S_MEM: begin
               if (mem_ready_i) begin
                  state_q  <= S_WB;
                  pc_en_q  <= 1'b1;
                  reg_we_q <= w_writes;
               end else begin
                  mem_req_q <= 1'b1;
                  mem_we_q  <= (w_op == C_OP_SW);
               end
            end
            S_DIVWAIT: begin
               if (div_done_i) begin
                  state_q  <= S_WB;
                  pc_en_q  <= 1'b1;
                  reg_we_q <= 1'b1;
               end
            end
            S_WB: begin
               state_q       <= S_FETCH;
               instr_ready_q <= 1'b1;
               count_q       <= count_q + 32'd1;
            end
            S_HALT: begin
               state_q <= S_HALT;
            end
            default: begin
               state_q       <= S_FETCH;
               instr_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign instr_ready_o = instr_ready_q;
   assign reg_we_o      = reg_we_q;
   assign mem_req_o     = mem_req_q;
   assign mem_we_o      = mem_we_q;
   assign div_start_o   = div_start_q;
   assign pc_en_o       = pc_en_q;
   assign pc_sel_o      = pc_sel_q;
   assign state_o       = state_q;
   assign instr_count_o = count_q;

   assign ra_o     = instr_q[18:14];
   assign rb_o     = instr_q[13:9];
   // LW and LI write the register named in the rb field
   assign rd_o     = ((w_op == C_OP_LW) || (w_op == C_OP_LI)) ? instr_q[13:9] : instr_q[8:4];
   // Loads/stores use the adder for address generation
   assign alu_op_o = w_is_alu ? w_op : 4'd0;
   assign imm_o    = DATAWIDTH'($signed(instr_q[31:19]));

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_unit
// Description : Directed self-checking bench for control_unit. Expected
//               write-back results are queued at accept and checked when the
//               controller reaches WB.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_DIV = 4'd3;
   localparam logic [3:0] OP_LW  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;
   localparam logic [3:0] OP_LI  = 4'd9;
   localparam logic [3:0] OP_BEQ = 4'd10;
   localparam logic [3:0] OP_BGE = 4'd12;
   localparam logic [3:0] OP_JMP = 4'd13;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] instr_i = 32'd0;
   logic        instr_valid_i = 1'b0;
   logic        eq_i = 1'b0;
   logic        gt_i = 1'b0;
   logic        mem_ready_i = 1'b0;
   logic        div_done_i = 1'b0;
   logic        instr_ready_o;
   logic [4:0]  ra_o, rb_o, rd_o;
   logic [3:0]  alu_op_o;
   logic [31:0] imm_o;
   logic        reg_we_o, mem_req_o, mem_we_o, div_start_o, pc_en_o, pc_sel_o;
   logic [2:0]  state_o;
   logic [31:0] instr_count_o;

   control_unit #(.DATAWIDTH(32)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .instr_i       (instr_i),
      .instr_valid_i (instr_valid_i),
      .instr_ready_o (instr_ready_o),
      .eq_i          (eq_i),
      .gt_i          (gt_i),
      .mem_ready_i   (mem_ready_i),
      .div_done_i    (div_done_i),
      .ra_o          (ra_o),
      .rb_o          (rb_o),
      .rd_o          (rd_o),
      .alu_op_o      (alu_op_o),
      .imm_o         (imm_o),
      .reg_we_o      (reg_we_o),
      .mem_req_o     (mem_req_o),
      .mem_we_o      (mem_we_o),
      .div_start_o   (div_start_o),
      .pc_en_o       (pc_en_o),
      .pc_sel_o      (pc_sel_o),
      .state_o       (state_o),
      .instr_count_o (instr_count_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct {
      logic        reg_we;
      logic [4:0]  rd;
      logic        pc_sel;
      logic [31:0] imm;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_count = 32'd0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [31:0] mk(input int off, input logic [4:0] ra, input logic [4:0] rb,
                                      input logic [4:0] rd, input logic [3:0] op);
      return {off[12:0], ra, rb, rd, op};
   endfunction

   // Issue one instruction and follow it to the next FETCH. nwait is the
   // number of MEM/DIVWAIT cycles; the done/ready input rises on the last one.
   task automatic run(input string tag, input int off, input logic [4:0] ra, input logic [4:0] rb,
                      input logic [4:0] rd, input logic [3:0] op, input int nwait,
                      input logic eq, input logic gt, input logic hold,
                      input logic exp_we, input logic [4:0] exp_rd, input logic exp_sel,
                      output int nreq, output int nwe, output int nstart);
      exp_t e, got;
      int   acc, guard, nw;
      e.reg_we = exp_we;
      e.rd     = exp_rd;
      e.pc_sel = exp_sel;
      e.imm    = 32'(off);
      e.lat    = 3 + nwait;
      instr_i       = mk(off, ra, rb, rd, op);
      instr_valid_i = 1'b1;
      eq_i          = eq;
      gt_i          = gt;
      guard = 0;
      while (!(state_o == 3'd0 && instr_ready_o) && guard < 20) begin
         step();
         guard++;
      end
      if (guard >= 20) chk({tag, "_fetch_timeout"}, 64'({state_o, instr_ready_o}), 64'({3'd0, 1'b1}));
      acc = cyc;
      sb.push_back(e);
      step();
      if (!hold) instr_valid_i = 1'b0;
      nreq = 0; nwe = 0; nstart = 0; nw = 0; guard = 0;
      while (!pc_en_o && guard < 40) begin
         if (mem_req_o) nreq++;
         if (mem_we_o) nwe++;
         if (div_start_o) nstart++;
         if (state_o == 3'd3 || state_o == 3'd4) begin
            nw++;
            mem_ready_i = (state_o == 3'd3) && (nw == nwait);
            div_done_i  = (state_o == 3'd4) && (nw == nwait);
         end
         step();
         guard++;
      end
      mem_ready_i = 1'b0;
      div_done_i  = 1'b0;
      chk({tag, "_pc_en"}, 64'(pc_en_o), 64'(1'b1));
      got = sb.pop_front();
      chk({tag, "_wb_cycle"}, 64'(cyc - acc), 64'(got.lat));
      chk({tag, "_reg_we"}, 64'(reg_we_o), 64'(got.reg_we));
      if (got.reg_we) chk({tag, "_rd"}, 64'(rd_o), 64'(got.rd));
      chk({tag, "_pc_sel"}, 64'(pc_sel_o), 64'(got.pc_sel));
      chk({tag, "_imm"}, 64'(imm_o), 64'(got.imm));
      exp_count = exp_count + 32'd1;
      step();
      chk({tag, "_next_accept"}, 64'({state_o, instr_ready_o}), 64'({3'd0, 1'b1}));
      chk({tag, "_latency"}, 64'(cyc - acc), 64'(got.lat + 1));
      chk({tag, "_count"}, 64'(instr_count_o), 64'(exp_count));
      instr_valid_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nreq, nwe, nstart, guard, nbad;

      // Reset held for two edges
      rst_i = 1'b1;
      step();
      step();
      chk("rst_state", 64'(state_o), 64'd0);
      chk("rst_ready", 64'(instr_ready_o), 64'd1);
      chk("rst_count", 64'(instr_count_o), 64'd0);
      chk("rst_strobes", 64'({reg_we_o, mem_req_o, mem_we_o, div_start_o, pc_en_o, pc_sel_o}), 64'd0);
      chk("rst_imm", 64'(imm_o), 64'd0);
      rst_i = 1'b0;

      // ADD r3 = r1 + r1, valid held; stray mem_ready must be ignored
      mem_ready_i = 1'b1;
      run("add", 0, 5'd1, 5'd1, 5'd3, OP_ADD, 0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, nreq, nwe, nstart);
      chk("add_no_memreq", 64'(nreq), 64'd0);

      // LW, memory ready on the third MEM cycle
      run("lw", 420, 5'd0, 5'd4, 5'd9, OP_LW, 3, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, nreq, nwe, nstart);
      chk("lw_memreq_cycles", 64'(nreq), 64'd3);
      chk("lw_mem_we", 64'(nwe), 64'd0);

      // SW, single-cycle memory: write strobe, no register write
      run("sw", 5, 5'd2, 5'd6, 5'd1, OP_SW, 1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, nreq, nwe, nstart);
      chk("sw_mem_we", 64'(nwe), 64'd1);

      // BGE -2: taken on gt, not taken when neither
      run("bge_t", -2, 5'd1, 5'd2, 5'd0, OP_BGE, 0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, nreq, nwe, nstart);
      run("bge_nt", -2, 5'd1, 5'd2, 5'd0, OP_BGE, 0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, nreq, nwe, nstart);
      run("beq_nt", 7, 5'd1, 5'd2, 5'd0, OP_BEQ, 0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, nreq, nwe, nstart);
      run("jmp", -100, 5'd0, 5'd0, 5'd0, OP_JMP, 0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, nreq, nwe, nstart);

      // LI writes rb
      run("li", 99, 5'd0, 5'd7, 5'd12, OP_LI, 0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, nreq, nwe, nstart);

      // DIV with done on the entry cycle, then a two-cycle wait
      run("div1", 0, 5'd1, 5'd2, 5'd5, OP_DIV, 1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, nreq, nwe, nstart);
      chk("div1_start_cycles", 64'(nstart), 64'd1);
      run("div2", 0, 5'd3, 5'd4, 5'd8, OP_DIV, 2, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, nreq, nwe, nstart);
      chk("div2_start_cycles", 64'(nstart), 64'd1);

      // DIV aborted by reset on the second DIVWAIT cycle
      instr_i       = mk(3, 5'd1, 5'd2, 5'd6, OP_DIV);
      instr_valid_i = 1'b1;
      step();
      instr_valid_i = 1'b0;
      guard = 0;
      nbad  = 0;
      while (state_o != 3'd4 && guard < 10) begin
         if (reg_we_o || pc_en_o) nbad++;
         step();
         guard++;
      end
      chk("divrst_enter_wait", 64'(state_o), 64'd4);
      step();
      chk("divrst_still_wait", 64'(state_o), 64'd4);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      chk("divrst_state", 64'({state_o, instr_ready_o}), 64'({3'd0, 1'b1}));
      chk("divrst_no_wb", 64'({reg_we_o, pc_en_o}), 64'd0);
      chk("divrst_early_strobes", 64'(nbad), 64'd0);
      exp_count = 32'd0;
      chk("divrst_count", 64'(instr_count_o), 64'(exp_count));
      chk("divrst_imm", 64'(imm_o), 64'd0);

      // Illegal opcode 1111
`ifdef CTRL_ILLEGAL_TRAP_EN
      instr_i       = mk(0, 5'd1, 5'd2, 5'd3, 4'hF);
      instr_valid_i = 1'b1;
      step();
      instr_valid_i = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("halt_state", 64'(state_o), 64'd6);
      chk("halt_ready", 64'(instr_ready_o), 64'd0);
      chk("halt_strobes", 64'({reg_we_o, mem_req_o, mem_we_o, div_start_o, pc_en_o, pc_sel_o}), 64'd0);
      chk("halt_count", 64'(instr_count_o), 64'(exp_count));
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      chk("halt_reset", 64'(state_o), 64'd0);
`else
      run("nop15", 0, 5'd1, 5'd2, 5'd3, 4'hF, 0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, nreq, nwe, nstart);
`endif

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32: width of the immediate output imm_o.
REQ-002 SHALL have port clk_i, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port instr_i, input, 32 bits: instruction, fields offset[31:19], ra[18:14], rb[13:9], rd[8:4], opcode[3:0].
REQ-005 SHALL have port instr_valid_i, input, 1 bit: fetch has instr_i ready.
REQ-006 SHALL have port instr_ready_o, output, 1 bit: controller accepts instr_i this cycle.
REQ-007 SHALL have ports eq_i and gt_i, inputs, 1 bit each: datapath comparisons ra==rb and ra>rb (signed).
REQ-008 SHALL have port mem_ready_i, input, 1 bit: data memory completes the current request.
REQ-009 SHALL have port div_done_i, input, 1 bit: divider result valid.
REQ-010 SHALL have outputs ra_o, rb_o, rd_o (5 bits each), alu_op_o (4 bits), imm_o (DATAWIDTH bits): decoded fields of the latched instruction.
REQ-011 SHALL have outputs reg_we_o, mem_req_o, mem_we_o, div_start_o, pc_en_o, pc_sel_o (1 bit each): datapath strobes.
REQ-012 SHALL have output state_o, 3 bits: current FSM state encoding; output instr_count_o, 32 bits: retired instruction count.

Function
REQ-013 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, DIVWAIT=4, WB=5, HALT=6.
REQ-014 SHALL in FETCH drive instr_ready_o=1; on instr_valid_i=1, latch instr_i and go to DECODE; otherwise stay in FETCH.
REQ-015 SHALL spend exactly one cycle in DECODE, then go to EXEC.
REQ-016 SHALL drive imm_o as offset[31:19] sign-extended to DATAWIDTH, held stable from DECODE until next accept.
REQ-017 SHALL in EXEC route LW/SW to MEM, DIV to DIVWAIT with div_start_o=1 for that single EXEC cycle, and all others to WB.
REQ-018 SHALL in MEM hold mem_req_o=1 (mem_we_o=1 for SW only) until mem_ready_i=1, then go to WB; mem_ready_i outside MEM is ignored.
REQ-019 SHALL in DIVWAIT wait for div_done_i=1, then go to WB; div_done_i in the same cycle as entry counts.
REQ-020 SHALL sample eq_i/gt_i in EXEC: BEQ taken if eq; BGT taken if gt; BGE taken if eq|gt; JMP always taken.
REQ-021 SHALL in WB assert pc_en_o=1 for one cycle, pc_sel_o=1 when a branch/JMP was taken (PC+imm) else 0 (PC+1).
REQ-022 SHALL in WB assert reg_we_o=1 for ADD, SUB, MUL, DIV, AND, OR, XOR, LW, LI; with destination rd_o=rd for ALU ops and rd_o=rb for LW and LI.
REQ-023 SHALL in WB increment instr_count_o by 1 (wrap 0xFFFFFFFF->0), then return to FETCH.
REQ-024 SHALL give per-instruction latency accept-to-next-accept: ALU/LI/branch 4 cycles; LW/SW 4+N cycles where N = MEM cycles; DIV 4+M cycles where M = DIVWAIT cycles.
REQ-025 SHALL drive alu_op_o=opcode for ALU ops and ADD (0000) for LW/SW (address computation).
REQ-026 SHALL keep all strobes 0 outside the states named above.

Reset
REQ-027 SHALL on rst_i=1 at a clock edge enter FETCH regardless of state, including mid-MEM or mid-DIVWAIT.
REQ-028 SHALL reset instr_count_o, the latched instruction, and all outputs to 0, except instr_ready_o, which is 1 as FETCH requires.
REQ-029 SHALL discard any in-flight instruction on reset without asserting reg_we_o or pc_en_o.

Configuration
REQ-030 SHALL, with macro CTRL_ILLEGAL_TRAP_EN defined, route opcodes 1110/1111 from EXEC to HALT, where all strobes and instr_ready_o are 0 until reset.
REQ-031 SHALL, without CTRL_ILLEGAL_TRAP_EN, execute opcodes 1110/1111 as NOP: WB with reg_we_o=0, pc_sel_o=0, count incremented.

Verification
REQ-032 SHALL verify reset: rst_i=1 two cycles -> state_o=0, instr_ready_o=1, instr_count_o=0, all strobes 0.
REQ-033 SHALL verify ADD ra=1 rb=1 rd=3 with instr_valid_i held -> reg_we_o=1 with rd_o=3 on cycle 3 after accept, next accept on cycle 4, count=1.
REQ-034 SHALL verify LW off=420 ra=0 rb=4 with mem_ready_i delayed 3 cycles -> mem_req_o high 3 cycles, mem_we_o=0, imm_o=420, reg_we_o with rd_o=4.
REQ-035 SHALL verify BGE off=-2 with eq_i=0 gt_i=1 -> pc_sel_o=1, imm_o=0xFFFFFFFE; repeat with eq_i=0 gt_i=0 -> pc_sel_o=0.
REQ-036 SHALL verify DIV with div_done_i after 5 cycles, rst_i asserted on DIVWAIT cycle 2 -> FETCH next cycle, no reg_we_o, count unchanged.
REQ-037 SHALL verify opcode 1111 -> HALT with instr_ready_o=0 when CTRL_ILLEGAL_TRAP_EN defined; otherwise NOP with count incremented.
